// File: rtl/gtrg_rdout_seq_if.sv
// Bus bundle between the GTRG FIFO / readout sources and the readout sequencer.
interface gtrg_rdout_seq_if;
  logic        EMPTY_B;
  logic [16:0] DAVSOUT;
  logic [11:0] BXCOUNTOUT;
  logic [3:0]  CFEBBX;
  logic        HOLD;
  logic [6:0]  SRC_DONE;
  logic        POP;
  logic [6:0]  SRC_RDEN;
  logic [15:0] HDR_DATA;
  logic        HDR_VLD;
  logic [6:0]  TMO_ERR;
  logic [11:0] EVT_CNT;
  logic        BUSY;

  modport master (
    output EMPTY_B, DAVSOUT, BXCOUNTOUT, CFEBBX, HOLD, SRC_DONE,
    input  POP, SRC_RDEN, HDR_DATA, HDR_VLD, TMO_ERR, EVT_CNT, BUSY
  );

  modport slave (
    input  EMPTY_B, DAVSOUT, BXCOUNTOUT, CFEBBX, HOLD, SRC_DONE,
    output POP, SRC_RDEN, HDR_DATA, HDR_VLD, TMO_ERR, EVT_CNT, BUSY
  );
endinterface

// File: rtl/gtrg_rdout_seq.sv
// Readout sequencer behind the GTRG FIFO: pops one event entry, emits a
// 3-word header, grants each source with DAV set (TMB, CFEB1..5, ALCT) under
// a timeout, then emits a trailer word.
module gtrg_rdout_seq #(
  parameter int unsigned TMO_CYC = 200
) (
  input logic CLK,
  input logic RST_B,
  gtrg_rdout_seq_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, SETL, CAPT, H0, H1, H2, SCAN, GRANT, TRL
  } state_t;

  state_t      state, state_nxt;
  logic [16:0] dav_q;
  logic [11:0] bx_q;
  logic [3:0]  cbx_q;
  logic [2:0]  k_q, k_nxt;
  logic [7:0]  tmo_q, tmo_nxt;
  logic [6:0]  err_q, err_nxt;
  logic [11:0] evt_q, evt_nxt;
  logic        cap;

  logic        pop_c;
  logic [6:0]  rden_c;
  logic [15:0] hdr_data_c;
  logic        hdr_vld_c;

  logic [6:0]  sel;
  logic [6:0]  src_en;
  logic        en_k;
  logic        done_k;
  logic        tmo_hit;

  // Source enables come only from DAV bits; MOVLP/LCT bits are header-only.
  assign src_en  = {dav_q[16], dav_q[5:1], dav_q[0]};
  assign sel     = 7'd1 << k_q;
  assign en_k    = (src_en & sel) != '0;
  assign done_k  = (bus.SRC_DONE & sel) != '0;
  assign tmo_hit = (tmo_q == 8'(TMO_CYC - 1));

  // Next-state, header word and strobe generation.
  always_comb begin
    state_nxt  = state;
    k_nxt      = k_q;
    tmo_nxt    = tmo_q;
    err_nxt    = err_q;
    evt_nxt    = evt_q;
    cap        = 1'b0;
    pop_c      = 1'b0;
    rden_c     = '0;
    hdr_data_c = '0;
    hdr_vld_c  = 1'b0;
    case (state)
      IDLE: if (bus.EMPTY_B) state_nxt = SETL;
      SETL: state_nxt = CAPT;
      CAPT: begin
        pop_c     = 1'b1;
        cap       = 1'b1;
        state_nxt = H0;
      end
      H0: begin
        hdr_data_c = {4'hA, bx_q};
        if (!bus.HOLD) begin
          hdr_vld_c = 1'b1;
          state_nxt = H1;
        end
      end
      H1: begin
        hdr_data_c = {4'hB, cbx_q, 1'b0, dav_q[16], dav_q[5:1], dav_q[0]};
        if (!bus.HOLD) begin
          hdr_vld_c = 1'b1;
          state_nxt = H2;
        end
      end
      H2: begin
        hdr_data_c = {4'hC, 2'b00, dav_q[15:11], dav_q[10:6]};
        if (!bus.HOLD) begin
          hdr_vld_c = 1'b1;
          k_nxt     = '0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (en_k) begin
          tmo_nxt   = '0;
          state_nxt = GRANT;
        end else if (k_q == 3'd6) begin
          state_nxt = TRL;
        end else begin
          k_nxt = k_q + 3'd1;
        end
      end
      GRANT: begin
        rden_c = sel;
        // DONE is tested first so a DONE on the timeout cycle sets no error.
        if (done_k || tmo_hit) begin
          if (!done_k) err_nxt = err_q | sel;
          if (k_q == 3'd6) begin
            state_nxt = TRL;
          end else begin
            k_nxt     = k_q + 3'd1;
            state_nxt = SCAN;
          end
        end else begin
          tmo_nxt = tmo_q + 8'd1;
        end
      end
      TRL: begin
        hdr_data_c = {4'hE, evt_q};
        if (!bus.HOLD) begin
          hdr_vld_c = 1'b1;
          evt_nxt   = evt_q + 12'd1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, event latch, scan index, timeout counter and flags.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state <= IDLE;
      dav_q <= '0;
      bx_q  <= '0;
      cbx_q <= '0;
      k_q   <= '0;
      tmo_q <= '0;
      err_q <= '0;
      evt_q <= '0;
    end else begin
      state <= state_nxt;
      k_q   <= k_nxt;
      tmo_q <= tmo_nxt;
      err_q <= err_nxt;
      evt_q <= evt_nxt;
      if (cap) begin
        dav_q <= bus.DAVSOUT;
        bx_q  <= bus.BXCOUNTOUT;
        cbx_q <= bus.CFEBBX;
      end
    end
  end

  assign bus.POP      = pop_c;
  assign bus.SRC_RDEN = rden_c;
  assign bus.HDR_DATA = hdr_data_c;
  assign bus.HDR_VLD  = hdr_vld_c;
  assign bus.TMO_ERR  = err_q;
  assign bus.EVT_CNT  = evt_q;
  assign bus.BUSY     = (state != IDLE);

endmodule

// File: tb/tb_gtrg_rdout_seq.sv
// Bench for gtrg_rdout_seq: FIFO/source model, list-based expectations.
module tb_gtrg_rdout_seq;
  localparam int unsigned TMO = 20;
  localparam int NEVER = 1000;

  logic CLK = 1'b0;
  logic RST_B;
  gtrg_rdout_seq_if bus();

  gtrg_rdout_seq #(.TMO_CYC(TMO)) dut (.CLK(CLK), .RST_B(RST_B), .bus(bus));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [16:0] dav;
    logic [11:0] bx;
    logic [3:0]  cbx;
  } ev_t;

  ev_t         fifo[$];
  logic [15:0] exp_words[$];
  int          exp_src[$];
  int          exp_glen[$];

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int          m_evt = 0;
  logic [6:0]  m_err = '0;

  int   dly = 2;
  bit   noise = 0;
  bit   rand_hold = 0;
  bit   hold_req = 0;
  bit   pop_pending = 0;
  int   pop_cnt = 0;
  int   step_no = 0;
  int   pop_step = -1;
  logic [6:0]  prev_rden = '0;
  logic [6:0]  cur_g = '0;
  int   gcnt = 0;
  int   glen = 0;
  logic [15:0] last_trl = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag, input logic [31:0] obs);
    n_chk++;
    assert (1'b0) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected nothing", tag, obs);
    end
  endtask

  // Reference: an event yields H0,H1,H2, grants for DAV sources in order, trailer.
  function automatic void push_event(input logic [16:0] dav, input logic [11:0] bx,
                                     input logic [3:0] cbx);
    ev_t e;
    bit  en;
    e.dav = dav; e.bx = bx; e.cbx = cbx;
    fifo.push_back(e);
    exp_words.push_back({4'hA, bx});
    exp_words.push_back({4'hB, cbx, 1'b0, dav[16], dav[5:1], dav[0]});
    exp_words.push_back({4'hC, 2'b00, dav[15:11], dav[10:6]});
    for (int s = 0; s < 7; s++) begin
      en = (s == 0) ? dav[0] : (s == 6) ? dav[16] : dav[s];
      if (en) begin
        exp_src.push_back(s);
        if (dly < int'(TMO)) exp_glen.push_back(dly + 1);
        else begin
          exp_glen.push_back(int'(TMO));
          m_err[s] = 1'b1;
        end
      end
    end
    exp_words.push_back({4'hE, 12'(m_evt)});
    m_evt = (m_evt + 1) % 4096;
  endfunction

  task automatic end_grant();
    if (exp_glen.size() == 0) fail("grant_len_unexpected", 32'(glen));
    else check("grant_len", 32'(glen), 32'(exp_glen.pop_front()));
    cur_g = '0;
  endtask

  // One clock: update FIFO head and source responses after the edge, then observe.
  task automatic step();
    logic [6:0] r;
    logic [6:0] d;
    ev_t        e;
    int         s;
    @(posedge CLK);
    #1;
    if (pop_pending) begin
      if (fifo.size() != 0) e = fifo.pop_front();
      pop_pending = 0;
    end
    bus.EMPTY_B = (fifo.size() != 0);
    if (fifo.size() != 0) begin
      bus.DAVSOUT    = fifo[0].dav;
      bus.BXCOUNTOUT = fifo[0].bx;
      bus.CFEBBX     = fifo[0].cbx;
    end else begin
      bus.DAVSOUT    = 17'($urandom);
      bus.BXCOUNTOUT = 12'($urandom);
      bus.CFEBBX     = 4'($urandom);
    end
    r = bus.SRC_RDEN;
    if (r != '0 && r == prev_rden) gcnt++;
    else gcnt = 0;
    prev_rden = r;
    d = (r != '0 && gcnt == dly) ? r : '0;
    if (noise) d = d | (7'($urandom) & ~r);
    bus.SRC_DONE = d;
    bus.HOLD = hold_req | (rand_hold && ($urandom_range(3) == 0));
    #1;
    step_no++;
    if (bus.POP) begin
      pop_cnt++;
      pop_pending = 1;
      if (pop_step < 0) pop_step = step_no;
    end
    r = bus.SRC_RDEN;
    if (r != '0) begin
      if (r != cur_g) begin
        if (cur_g != '0) end_grant();
        if (exp_src.size() == 0) fail("grant_unexpected", 32'(r));
        else begin
          s = exp_src.pop_front();
          check("grant_sel", 32'(r), 32'(7'd1 << s));
        end
        cur_g = r;
        glen = 1;
      end else glen++;
    end else if (cur_g != '0) end_grant();
    if (bus.HDR_VLD) begin
      if (bus.HOLD) fail("vld_during_hold", 32'(bus.HDR_DATA));
      if (exp_words.size() == 0) fail("word_unexpected", 32'(bus.HDR_DATA));
      else check("hdr_word", 32'(bus.HDR_DATA), 32'(exp_words.pop_front()));
      if (bus.HDR_DATA[15:12] == 4'hE) last_trl = bus.HDR_DATA;
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    bit done = 0;
    while (!done && n < budget) begin
      step();
      n++;
      if (fifo.size() == 0 && !pop_pending && bus.BUSY === 1'b0 && cur_g == '0) done = 1;
    end
    if (!done) fail({"timeout_", tag}, 32'(n));
    check({tag, "_words_left"}, 32'(exp_words.size()), 32'd0);
    check({tag, "_grants_left"}, 32'(exp_src.size()), 32'd0);
    check({tag, "_evt_cnt"}, 32'(bus.EVT_CNT), 32'(m_evt));
    check({tag, "_tmo_err"}, 32'(bus.TMO_ERR), 32'(m_err));
  endtask

  task automatic clear_model();
    m_evt = 0;
    m_err = '0;
    fifo.delete();
    exp_words.delete();
    exp_src.delete();
    exp_glen.delete();
    cur_g = '0;
    prev_rden = '0;
    gcnt = 0;
    pop_pending = 0;
  endtask

  task automatic do_reset();
    #2 RST_B = 1'b0;
    clear_model();
    step();
    step();
    #2 RST_B = 1'b1;
  endtask

  initial begin
    int s0;
    int pc;
    int n;
    logic [15:0] h1;
    RST_B = 1'b0;
    bus.EMPTY_B = 1'b0;
    bus.DAVSOUT = '0;
    bus.BXCOUNTOUT = '0;
    bus.CFEBBX = '0;
    bus.HOLD = 1'b0;
    bus.SRC_DONE = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_outputs",
          32'({bus.POP, bus.SRC_RDEN, bus.HDR_DATA, bus.HDR_VLD, bus.BUSY}), 32'd0);
    check("reset_counters", 32'({bus.TMO_ERR, bus.EVT_CNT}), 32'd0);
    @(negedge CLK);
    RST_B = 1'b1;

    // Basic event: TMB, CFEB1, ALCT granted; DONE 3 cycles into each grant.
    dly = 3;
    push_event(17'h1_0003, 12'h123, 4'h5);
    s0 = step_no + 1;
    pop_step = -1;
    pc = pop_cnt;
    wait_idle(200, "basic");
    check("pop_latency", 32'(pop_step - s0), 32'd2);
    check("pop_count", 32'(pop_cnt - pc), 32'd1);
    check("basic_trailer", 32'(last_trl), 32'h0000_E000);
    check("basic_evt_one", 32'(bus.EVT_CNT), 32'd1);

    // Reset mid-GRANT clears everything asynchronously.
    dly = NEVER;
    push_event(17'h0_0002, 12'h3C5, 4'hA);
    n = 0;
    while (bus.SRC_RDEN !== 7'h02 && n < 60) begin
      step();
      n++;
    end
    if (bus.SRC_RDEN !== 7'h02) fail("reset_grant_not_reached", 32'(bus.SRC_RDEN));
    #2 RST_B = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({bus.POP, bus.SRC_RDEN, bus.HDR_DATA, bus.HDR_VLD, bus.BUSY}), 32'd0);
    check("async_reset_counters", 32'({bus.TMO_ERR, bus.EVT_CNT}), 32'd0);
    clear_model();
    step();
    #2 RST_B = 1'b1;
    pc = pop_cnt;
    repeat (5) step();
    check("post_reset_no_pop", 32'(pop_cnt - pc), 32'd0);
    check("post_reset_idle", 32'(bus.BUSY), 32'd0);

    // Timeout on CFEB2: grant lasts TMO cycles, error flag set.
    dly = NEVER;
    push_event(17'h0_0004, 12'h0F0, 4'h1);
    wait_idle(300, "timeout");
    check("timeout_flag", 32'(bus.TMO_ERR), 32'h04);

    // DONE on the last allowed cycle wins over the timeout.
    dly = int'(TMO) - 1;
    push_event(17'h0_0008, 12'h777, 4'h2);
    wait_idle(300, "done_on_tmo");
    check("done_on_tmo_flag", 32'(bus.TMO_ERR), 32'h04);

    // HOLD for 5 cycles in H1; MOVLP/LCT bits are not enables.
    dly = 0;
    push_event(17'h0_FFE0, 12'hABC, 4'h9);
    n = 0;
    while (!(bus.HDR_VLD === 1'b1 && bus.HDR_DATA[15:12] == 4'hA) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) fail("hold_h0_not_seen", 32'(n));
    h1 = (exp_words.size() != 0) ? exp_words[0] : 16'h0;
    hold_req = 1;
    repeat (5) begin
      step();
      check("hold_vld", 32'(bus.HDR_VLD), 32'd0);
      check("hold_data", 32'(bus.HDR_DATA), 32'(h1));
    end
    hold_req = 0;
    wait_idle(200, "hold");

    // Randomized batches with backpressure and noise on other DONE bits.
    noise = 1;
    rand_hold = 1;
    for (int b = 0; b < 8; b++) begin
      case ($urandom_range(6))
        5: dly = int'(TMO) - 1;
        6: dly = NEVER;
        default: dly = int'($urandom_range(4));
      endcase
      n = int'($urandom_range(4, 1));
      for (int i = 0; i < n; i++)
        push_event(17'($urandom), 12'($urandom), 4'($urandom));
      wait_idle(4000, "random");
    end
    noise = 0;
    rand_hold = 0;

    // 4096 back-to-back empty-DAV events: counter wraps.
    do_reset();
    dly = 0;
    for (int i = 0; i < 4096; i++) push_event(17'h0, 12'($urandom), 4'($urandom));
    wait_idle(70000, "wrap");
    check("wrap_last_trailer", 32'(last_trl), 32'h0000_EFFF);
    check("wrap_evt_cnt", 32'(bus.EVT_CNT), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
